// File: rtl/csr_access_unit.sv
// Execute-stage initiator for the CSR register-file port: one Zicsr instruction in flight,
// sequenced IDLE -> READ -> WRITE -> RESP. Optional illegal-access checking via CSR_ILLEGAL_CHK_EN.
`ifndef XLEN
`define XLEN 32
`endif

module csr_access_unit #(
    parameter int DW = `XLEN
) (
    input  logic          clk,
    input  logic          rst_n,
    // Request: a transfer happens on the rising edge where req_valid && req_ready.
    // Response: a transfer happens on the rising edge where rsp_valid && rsp_ready;
    // rsp_* stay stable while rsp_valid is high and rsp_ready is low.
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [2:0]    req_funct3,
    input  logic [11:0]   req_csr_idx,
    input  logic [4:0]    req_rs1_idx,
    input  logic [DW-1:0] req_rs1_data,
    input  logic [4:0]    req_rd_idx,
    output logic          csr_rd_en,
    output logic          csr_wb_en,
    output logic [11:0]   csr_idx,
    output logic [DW-1:0] csr_wdata,
    input  logic [DW-1:0] csr_rdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [4:0]    rsp_rd_idx,
    output logic          rsp_rd_we,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_illegal,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    state_e        state_q;
    logic [2:0]    funct3_q;
    logic [4:0]    rs1_idx_q;
    logic [DW-1:0] rs1_data_q;
    logic [4:0]    rd_idx_q;
    logic [DW-1:0] old_q;
    logic          illegal_q;
    logic          wb_allow_q;

    logic          req_ready_q;
    logic          csr_rd_en_q;
    logic          csr_wb_en_q;
    logic [11:0]   csr_idx_q;
    logic [DW-1:0] csr_wdata_q;
    logic          rsp_valid_q;
    logic [4:0]    rsp_rd_idx_q;
    logic          rsp_rd_we_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          rsp_illegal_q;

    function automatic logic op_valid(input logic [2:0] f3);
        return f3[1:0] != 2'b00;
    endfunction

    function automatic logic is_rw(input logic [2:0] f3);
        return f3[1:0] == 2'b01;
    endfunction

    // Set/clear forms with rs1==0 (or uimm==0) must not write the CSR.
    function automatic logic write_needed(input logic [2:0] f3, input logic [4:0] rs1);
        return op_valid(f3) && (is_rw(f3) || (rs1 != 5'd0));
    endfunction

    // CSRRW/CSRRWI with rd==0 must not read the CSR (no read side effects).
    function automatic logic read_needed(input logic [2:0] f3, input logic [4:0] rd);
        return op_valid(f3) && !(is_rw(f3) && (rd == 5'd0));
    endfunction

    logic          illegal_d;
    logic          rd_allow_d;
    logic          wb_allow_d;
    logic [DW-1:0] old_d;
    logic [DW-1:0] src_d;
    logic [DW-1:0] wdata_d;

    always_comb begin
        illegal_d = 1'b0;
`ifdef CSR_ILLEGAL_CHK_EN
        illegal_d = !op_valid(req_funct3) ||
                    (write_needed(req_funct3, req_rs1_idx) && (req_csr_idx[11:10] == 2'b11));
`endif
        rd_allow_d = read_needed(req_funct3, req_rd_idx) && !illegal_d;
        wb_allow_d = write_needed(req_funct3, req_rs1_idx) && !illegal_d;
    end

    always_comb begin
        old_d = csr_rd_en_q ? csr_rdata : '0;
        src_d = funct3_q[2] ? DW'(rs1_idx_q) : rs1_data_q;
        case (funct3_q[1:0])
            2'b01:   wdata_d = src_d;
            2'b10:   wdata_d = old_d | src_d;
            2'b11:   wdata_d = old_d & ~src_d;
            default: wdata_d = '0;
        endcase
        if (!wb_allow_q) begin
            wdata_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            funct3_q      <= '0;
            rs1_idx_q     <= '0;
            rs1_data_q    <= '0;
            rd_idx_q      <= '0;
            old_q         <= '0;
            illegal_q     <= 1'b0;
            wb_allow_q    <= 1'b0;
            req_ready_q   <= 1'b1;
            csr_rd_en_q   <= 1'b0;
            csr_wb_en_q   <= 1'b0;
            csr_idx_q     <= '0;
            csr_wdata_q   <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rd_idx_q  <= '0;
            rsp_rd_we_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_illegal_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q     <= ST_READ;
                        funct3_q    <= req_funct3;
                        rs1_idx_q   <= req_rs1_idx;
                        rs1_data_q  <= req_rs1_data;
                        rd_idx_q    <= req_rd_idx;
                        illegal_q   <= illegal_d;
                        wb_allow_q  <= wb_allow_d;
                        req_ready_q <= 1'b0;
                        csr_rd_en_q <= rd_allow_d;
                        csr_idx_q   <= req_csr_idx;
                    end
                end
                ST_READ: begin
                    state_q     <= ST_WRITE;
                    old_q       <= old_d;
                    csr_rd_en_q <= 1'b0;
                    csr_wb_en_q <= wb_allow_q;
                    csr_wdata_q <= wdata_d;
                end
                ST_WRITE: begin
                    state_q       <= ST_RESP;
                    csr_wb_en_q   <= 1'b0;
                    csr_wdata_q   <= '0;
                    csr_idx_q     <= '0;
                    rsp_valid_q   <= 1'b1;
                    rsp_rd_idx_q  <= rd_idx_q;
                    rsp_rd_we_q   <= (rd_idx_q != 5'd0) && op_valid(funct3_q) && !illegal_q;
                    rsp_rdata_q   <= old_q;
                    rsp_illegal_q <= illegal_q;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q       <= ST_IDLE;
                        req_ready_q   <= 1'b1;
                        rsp_valid_q   <= 1'b0;
                        rsp_rd_idx_q  <= '0;
                        rsp_rd_we_q   <= 1'b0;
                        rsp_rdata_q   <= '0;
                        rsp_illegal_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready   = req_ready_q;
    assign csr_rd_en   = csr_rd_en_q;
    assign csr_wb_en   = csr_wb_en_q;
    assign csr_idx     = csr_idx_q;
    assign csr_wdata   = csr_wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rd_idx  = rsp_rd_idx_q;
    assign rsp_rd_we   = rsp_rd_we_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_illegal = rsp_illegal_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit: hand-computed vectors covering each CSR form,
// suppressed read/write cases, response back-pressure, mid-operation reset and illegal checks.
`timescale 1ns/1ps

module tb_csr_access_unit;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_funct3;
  logic [11:0]   req_csr_idx;
  logic [4:0]    req_rs1_idx;
  logic [DW-1:0] req_rs1_data;
  logic [4:0]    req_rd_idx;
  logic          csr_rd_en;
  logic          csr_wb_en;
  logic [11:0]   csr_idx;
  logic [DW-1:0] csr_wdata;
  logic [DW-1:0] csr_rdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [4:0]    rsp_rd_idx;
  logic          rsp_rd_we;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_illegal;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  csr_access_unit #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_idx(req_csr_idx), .req_rs1_idx(req_rs1_idx), .req_rs1_data(req_rs1_data),
    .req_rd_idx(req_rd_idx),
    .csr_rd_en(csr_rd_en), .csr_wb_en(csr_wb_en), .csr_idx(csr_idx),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd_idx(rsp_rd_idx),
    .rsp_rd_we(rsp_rd_we), .rsp_rdata(rsp_rdata), .rsp_illegal(rsp_illegal),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CSR_ILLEGAL_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one instruction through the four phases and checks every phase.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [11:0] idx,
                        input logic [4:0] rs1, input logic [DW-1:0] rs1_data,
                        input logic [4:0] rd, input logic [DW-1:0] rdata,
                        input logic e_rd, input logic e_wb, input logic [DW-1:0] e_wdata,
                        input logic [DW-1:0] e_rsp, input logic e_we, input logic e_ill,
                        input int hold);
    check({tag, ".req_ready"}, DW'(req_ready), DW'(1));
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_csr_idx  = idx;
    req_rs1_idx  = rs1;
    req_rs1_data = rs1_data;
    req_rd_idx   = rd;
    step();
    req_valid = 1'b0;
    csr_rdata = rdata;
    check({tag, ".rd_en"}, DW'(csr_rd_en), DW'(e_rd));
    check({tag, ".rd_wb_en"}, DW'(csr_wb_en), DW'(0));
    check({tag, ".rd_idx"}, DW'(csr_idx), DW'(idx));
    check({tag, ".busy"}, DW'(req_ready), DW'(0));
    step();
    csr_rdata = '0;
    check({tag, ".wb_en"}, DW'(csr_wb_en), DW'(e_wb));
    check({tag, ".wr_rd_en"}, DW'(csr_rd_en), DW'(0));
    check({tag, ".wr_idx"}, DW'(csr_idx), DW'(idx));
    if (e_wb) check({tag, ".wdata"}, csr_wdata, e_wdata);
    step();
    for (int i = 0; i <= hold; i++) begin
      check({tag, ".rsp_valid"}, DW'(rsp_valid), DW'(1));
      check({tag, ".rsp_rdata"}, rsp_rdata, e_rsp);
      check({tag, ".rsp_rd_idx"}, DW'(rsp_rd_idx), DW'(rd));
      check({tag, ".rsp_rd_we"}, DW'(rsp_rd_we), DW'(e_we));
      check({tag, ".rsp_illegal"}, DW'(rsp_illegal), DW'(e_ill));
      check({tag, ".resp_strobes"}, DW'({csr_rd_en, csr_wb_en}), DW'(0));
      check({tag, ".resp_idx"}, DW'(csr_idx), DW'(0));
      if (i < hold) begin
        check({tag, ".hold_ready"}, DW'(req_ready), DW'(0));
        step();
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check({tag, ".done_valid"}, DW'(rsp_valid), DW'(0));
    check({tag, ".done_ready"}, DW'(req_ready), DW'(1));
  endtask

  initial begin
    int seen_wb;
    int seen_rsp;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_funct3 = '0;
    req_csr_idx = '0;
    req_rs1_idx = '0;
    req_rs1_data = '0;
    req_rd_idx = '0;
    csr_rdata = '0;
    rsp_ready = 1'b0;
    repeat (3) step();
    check("reset.req_ready", DW'(req_ready), DW'(1));
    check("reset.strobes", DW'({csr_rd_en, csr_wb_en, rsp_valid}), DW'(0));
    check("reset.rsp", DW'({rsp_rd_we, rsp_illegal, rsp_rd_idx}), DW'(0));
    check("reset.data", csr_wdata | rsp_rdata | DW'(csr_idx), DW'(0));
    rst_n = 1'b1;
    step();
    check("idle.stable_ready", DW'(req_ready), DW'(1));

    //      tag        f3      idx      rs1    rs1_data      rd     rdata         rd  wb  wdata         rsp           we  ill hold
    run_op("rw",       3'b001, 12'h300, 5'd7,  32'h0000_00A5, 5'd5, 32'h0000_0008, 1, 1, 32'h0000_00A5, 32'h0000_0008, 1, 0, 0);
    run_op("rs",       3'b010, 12'h304, 5'd2,  32'h0000_0080, 5'd6, 32'h0000_0008, 1, 1, 32'h0000_0088, 32'h0000_0008, 1, 0, 0);
    run_op("rs_x0",    3'b010, 12'h304, 5'd0,  32'h0000_0080, 5'd6, 32'h0000_0008, 1, 0, 32'h0,         32'h0000_0008, 1, 0, 0);
    run_op("rci",      3'b111, 12'h340, 5'd3,  32'hFFFF_FFFF, 5'd1, 32'h0000_000F, 1, 1, 32'h0000_000C, 32'h0000_000F, 1, 0, 0);
    run_op("rw_rd0",   3'b001, 12'h305, 5'd9,  32'h1234_5678, 5'd0, 32'hDEAD_BEEF, 0, 1, 32'h1234_5678, 32'h0,         0, 0, 0);
    run_op("rsi",      3'b110, 12'h341, 5'd16, 32'hFFFF_0000, 5'd3, 32'h0000_0001, 1, 1, 32'h0000_0011, 32'h0000_0001, 1, 0, 0);
    run_op("rc",       3'b011, 12'h342, 5'd4,  32'hF0F0_F0F0, 5'd31, 32'hFFFF_00FF, 1, 1, 32'h0F0F_000F, 32'hFFFF_00FF, 1, 0, 0);
    run_op("rwi",      3'b101, 12'h343, 5'd31, 32'hAAAA_AAAA, 5'd8, 32'h0000_0100, 1, 1, 32'h0000_001F, 32'h0000_0100, 1, 0, 0);
    run_op("rsv100",   3'b100, 12'h300, 5'd5,  32'h0000_00FF, 5'd4, 32'h0000_0077, 0, 0, 32'h0,         32'h0,         0, CHK, 0);
    run_op("rsv000",   3'b000, 12'h300, 5'd5,  32'h0000_00FF, 5'd4, 32'h0000_0077, 0, 0, 32'h0,         32'h0,         0, CHK, 0);
    run_op("hold",     3'b001, 12'h300, 5'd7,  32'h0000_005A, 5'd12, 32'h0000_00A5, 1, 1, 32'h0000_005A, 32'h0000_00A5, 1, 0, 5);
    run_op("ro_write", 3'b001, 12'hC00, 5'd1,  32'h0000_0042, 5'd2, 32'h0000_0033,
           !CHK, !CHK, 32'h0000_0042, CHK ? 32'h0 : 32'h0000_0033, !CHK, CHK, 0);
    run_op("ro_read",  3'b010, 12'hC01, 5'd0,  32'h0000_0042, 5'd2, 32'h0000_0099, 1, 0, 32'h0,         32'h0000_0099, 1, 0, 0);

    // Reset asserted while the unit is in READ: nothing may leak out afterwards.
    req_valid = 1'b1;
    req_funct3 = 3'b001;
    req_csr_idx = 12'h300;
    req_rs1_idx = 5'd1;
    req_rs1_data = 32'h0000_0055;
    req_rd_idx = 5'd5;
    step();
    req_valid = 1'b0;
    check("rst_mid.in_read", DW'(csr_rd_en), DW'(1));
    rst_n = 1'b0;
    #1;
    check("rst_mid.async_ready", DW'(req_ready), DW'(1));
    check("rst_mid.async_rd_en", DW'(csr_rd_en), DW'(0));
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen_wb = 0;
    seen_rsp = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen_wb += int'(csr_wb_en);
      seen_rsp += int'(rsp_valid);
    end
    rsp_ready = 1'b0;
    check("rst_mid.no_wb", DW'(seen_wb), DW'(0));
    check("rst_mid.no_rsp", DW'(seen_rsp), DW'(0));
    check("rst_mid.ready", DW'(req_ready), DW'(1));

    run_op("after_rst", 3'b011, 12'h300, 5'd1, 32'h0000_0001, 5'd9, 32'h0000_0003, 1, 1, 32'h0000_0002, 32'h0000_0003, 1, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
